// File: rtl/analog_core_ctrl_if.sv
// Read-side bundle for analog_core_ctrl: FIFO word/handshake plus the overflow flag.
// master = controller (drives data), slave = consumer (wishbone / logic-analyzer side).
interface analog_core_ctrl_if #(
  parameter int unsigned CNT_W = 10
) ();
  logic [CNT_W:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           ovf;
  logic           ovf_clr;

  modport master (
    output dout,
    output dout_valid,
    output ovf,
    input  dout_ready,
    input  ovf_clr
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  ovf,
    output dout_ready,
    output ovf_clr
  );
endinterface

// File: rtl/analog_core_ctrl.sv
// Digital-side controller for one analog channel: clock/LO generation, 1-bit feedback
// sampling, ones-count decimation and a first-word-fall-through output FIFO.
// Optional feature: define ACTRL_FB_OVERRIDE_EN to add fb_ovr_en/fb_ovr_val ports that
// force fb from software while the decimator keeps counting the comparator.
module analog_core_ctrl #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic             cfg_div2,
  input  logic [DIV_W-1:0] cclk_div,
  input  logic [7:0]       lo_div,
  input  logic [CNT_W-1:0] dec_len,
  input  logic             comp_high,
  input  logic             phi1b_dig,
`ifdef ACTRL_FB_OVERRIDE_EN
  input  logic             fb_ovr_en,
  input  logic             fb_ovr_val,
`endif
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb,
  analog_core_ctrl_if.master io_rd
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_cclk;
  logic [7:0]       r_lo_cnt;
  logic [7:0]       r_lo_div;
  logic             r_lo;
  logic             r_div2;
  logic [2:0]       r_phi_s;
  logic [1:0]       r_comp_s;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] r_dec_len;
  logic [CNT_W:0]   r_ones;
  logic             r_fb;
  logic [CNT_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;

  logic             w_div_tc;
  logic             w_cclk_rise;
  logic             w_evt;
  logic             w_comp;
  logic             w_win_tc;
  logic [CNT_W:0]   w_ones_nxt;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;

  // cclk_div is compared live so a config change takes effect on the current half period.
  assign w_div_tc    = (r_div_cnt == cclk_div);
  assign w_cclk_rise = en && w_div_tc && !r_cclk;

  // Half-period divider producing cclk.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_div_cnt <= '0;
      r_cclk    <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_cclk    <= 1'b0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_cclk    <= ~r_cclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // LO counter advanced on each cclk rise; lo_div is captured while idle and at each wrap.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_lo_cnt <= '0;
      r_lo_div <= '0;
      r_lo     <= 1'b0;
    end else if (!en) begin
      r_lo_cnt <= '0;
      r_lo_div <= lo_div;
      r_lo     <= 1'b0;
    end else if (w_cclk_rise) begin
      if (r_lo_cnt == r_lo_div) begin
        r_lo_cnt <= '0;
        r_lo_div <= lo_div;
        r_lo     <= ~r_lo;
      end else begin
        r_lo_cnt <= r_lo_cnt + 8'd1;
      end
    end
  end

  // Static mode register and input synchronizers (third phi flop is the edge detector).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_div2   <= 1'b0;
      r_phi_s  <= '0;
      r_comp_s <= '0;
    end else begin
      r_div2   <= cfg_div2;
      r_phi_s  <= {r_phi_s[1:0], phi1b_dig};
      r_comp_s <= {r_comp_s[0], comp_high};
    end
  end

  assign w_evt      = en && r_phi_s[1] && !r_phi_s[2];
  assign w_comp     = r_comp_s[1];
  assign w_win_tc   = (r_smp_cnt == r_dec_len);
  assign w_ones_nxt = r_ones + {{CNT_W{1'b0}}, w_comp};
  assign w_push     = w_evt && w_win_tc;

  // Decimator: count ones over dec_len+1 samples; the closing sample is part of the word.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_smp_cnt <= '0;
      r_dec_len <= '0;
      r_ones    <= '0;
    end else if (!en) begin
      r_smp_cnt <= '0;
      r_dec_len <= dec_len;
      r_ones    <= '0;
    end else if (w_evt) begin
      if (w_win_tc) begin
        r_smp_cnt <= '0;
        r_dec_len <= dec_len;
        r_ones    <= '0;
      end else begin
        r_smp_cnt <= r_smp_cnt + CNT_W'(1);
        r_ones    <= w_ones_nxt;
      end
    end
  end

  // Feedback bit: sampled comparator at each phase boundary, or the override value.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_fb <= 1'b0;
`ifdef ACTRL_FB_OVERRIDE_EN
    end else if (fb_ovr_en) begin
      r_fb <= fb_ovr_val;
`endif
    end else if (w_evt) begin
      r_fb <= w_comp;
    end
  end

  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && io_rd.dout_ready;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // FIFO storage; no reset needed since dout is gated while empty.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_ones_nxt;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a new drop wins over ovf_clr).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (io_rd.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cclk             = r_cclk;
  assign lo               = r_lo;
  assign div2             = r_div2;
  assign fb               = r_fb;
  assign io_rd.dout       = w_empty ? '0 : r_mem[r_rptr];
  assign io_rd.dout_valid = !w_empty;
  assign io_rd.ovf        = r_ovf;

endmodule

// File: tb/tb_analog_core_ctrl.sv
// Directed self-checking bench for analog_core_ctrl.
module tb_analog_core_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en;
  logic       cfg_div2;
  logic [7:0] cclk_div;
  logic [7:0] lo_div;
  logic [9:0] dec_len;
  logic       comp;
  logic       phi;
  logic       cclk;
  logic       div2;
  logic       lo;
  logic       fb;
`ifdef ACTRL_FB_OVERRIDE_EN
  logic       fb_ovr_en;
  logic       fb_ovr_val;
`endif

  int n_vec = 0;
  int n_err = 0;

  analog_core_ctrl_if #(.CNT_W(10)) rd_if ();

  analog_core_ctrl #(
    .DIV_W      (8),
    .CNT_W      (10),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en         (en),
    .cfg_div2   (cfg_div2),
    .cclk_div   (cclk_div),
    .lo_div     (lo_div),
    .dec_len    (dec_len),
    .comp_high  (comp),
    .phi1b_dig  (phi),
`ifdef ACTRL_FB_OVERRIDE_EN
    .fb_ovr_en  (fb_ovr_en),
    .fb_ovr_val (fb_ovr_val),
`endif
    .cclk       (cclk),
    .div2       (div2),
    .lo         (lo),
    .fb         (fb),
    .io_rd      (rd_if)
  );

  always #5 clk = ~clk;

  // One phi1b_dig period with comparator value c; called just after a negedge.
  task automatic pulse(input logic c, input int half);
    comp = c;
    phi  = 1'b1;
    repeat (half) @(negedge clk);
    phi  = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  // Hold dout_ready for exactly one rising edge.
  task automatic pop1;
    rd_if.dout_ready = 1'b1;
    @(negedge clk);
    rd_if.dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    en = 1'b0; cfg_div2 = 1'b0; cclk_div = 8'd3; lo_div = 8'd1; dec_len = 10'd7;
    comp = 1'b0; phi = 1'b0; rd_if.dout_ready = 1'b0; rd_if.ovf_clr = 1'b0;
`ifdef ACTRL_FB_OVERRIDE_EN
    fb_ovr_en = 1'b0; fb_ovr_val = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({cclk, lo, fb, div2, rd_if.dout_valid, rd_if.ovf} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_bits: got %b want 000000",
               {cclk, lo, fb, div2, rd_if.dout_valid, rd_if.ovf});
    end
    n_vec++;
    if (rd_if.dout !== 11'd0) begin
      n_err++;
      $display("FAIL reset_dout: got %0d want 0", rd_if.dout);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div2;
    cfg_div2 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (div2 !== 1'b1) begin
      n_err++;
      $display("FAIL div2_reg: got %b want 1", div2);
    end
  endtask

  task automatic test_clkgen;
    logic exp_c;
    logic exp_l;
    cclk_div = 8'd3; lo_div = 8'd1;
    @(negedge clk);
    en = 1'b1;
    // cclk rises after 4 edges, period 8; lo first rises at cclk rise #2 (edge 12), period 32
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      exp_c = ((n / 4) % 2) == 1;
      exp_l = (n >= 12) && (((n - 12) / 16) % 2 == 0);
      n_vec++;
      if (cclk !== exp_c || lo !== exp_l) begin
        n_err++;
        $display("FAIL clkgen n=%0d: got cclk=%b lo=%b want cclk=%b lo=%b",
                 n, cclk, lo, exp_c, exp_l);
      end
    end
    en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cclk !== 1'b0 || lo !== 1'b0) begin
      n_err++;
      $display("FAIL clkgen_disable: got cclk=%b lo=%b want 0 0", cclk, lo);
    end
  endtask

  task automatic test_decimate;
    logic [3:0] pat;
    logic       c;
    logic       prev;
    pat = 4'b1101;
    prev = 1'b0;
    dec_len = 10'd7;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      c = pat[k % 4];
      comp = c;
      phi = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (fb !== prev) begin
        n_err++;
        $display("FAIL fb_early k=%0d: got %b want %b", k, fb, prev);
      end
      if (k == 7) begin
        n_vec++;
        if (rd_if.dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL valid_early: got %b want 0", rd_if.dout_valid);
        end
      end
      @(negedge clk);
      if (k == 7) begin
        n_vec++;
        if (rd_if.dout_valid !== 1'b1) begin
          n_err++;
          $display("FAIL valid_latency: got %b want 1", rd_if.dout_valid);
        end
      end
      @(negedge clk);
      n_vec++;
      if (fb !== c) begin
        n_err++;
        $display("FAIL fb_follow k=%0d: got %b want %b", k, fb, c);
      end
      repeat (4) @(negedge clk);
      phi = 1'b0;
      repeat (8) @(negedge clk);
      prev = c;
    end
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (rd_if.dout_valid !== 1'b1 || rd_if.dout !== 11'd6) begin
        n_err++;
        $display("FAIL dec_word%0d: got v=%b d=%0d want v=1 d=6", w, rd_if.dout_valid, rd_if.dout);
      end
      pop1();
    end
    n_vec++;
    if (rd_if.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dec_empty: got %b want 0", rd_if.dout_valid);
    end
  endtask

  task automatic test_max_window;
    en = 1'b0;
    dec_len = 10'd1023;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 1024; i++) pulse(1'b1, 4);
    n_vec++;
    if (rd_if.dout_valid !== 1'b1 || rd_if.dout !== 11'd1024) begin
      n_err++;
      $display("FAIL max_window: got v=%b d=%0d want v=1 d=1024", rd_if.dout_valid, rd_if.dout);
    end
    pop1();
    n_vec++;
    if (rd_if.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL max_empty: got %b want 0", rd_if.dout_valid);
    end
  endtask

  task automatic test_fifo_ovf;
    logic        wa [5];
    logic        wb [5];
    logic [10:0] exp [4];
    wa = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    wb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp = '{11'd1, 11'd0, 11'd2, 11'd2};
    en = 1'b0;
    dec_len = 10'd1;
    @(negedge clk);
    en = 1'b1;
    // words 2,1,0,2 fill the FIFO; the fifth (1) is dropped
    for (int i = 0; i < 5; i++) begin
      pulse(wa[i], 4);
      pulse(wb[i], 4);
      if (i == 3) begin
        n_vec++;
        if (rd_if.ovf !== 1'b0 || rd_if.dout !== 11'd2) begin
          n_err++;
          $display("FAIL fill: got ovf=%b d=%0d want ovf=0 d=2", rd_if.ovf, rd_if.dout);
        end
      end
    end
    n_vec++;
    if (rd_if.ovf !== 1'b1 || rd_if.dout !== 11'd2) begin
      n_err++;
      $display("FAIL overflow: got ovf=%b d=%0d want ovf=1 d=2", rd_if.ovf, rd_if.dout);
    end
    rd_if.ovf_clr = 1'b1;
    @(negedge clk);
    rd_if.ovf_clr = 1'b0;
    n_vec++;
    if (rd_if.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: got %b want 0", rd_if.ovf);
    end
    // push of word 2 coincides with popping head 2 while full
    pulse(1'b1, 4);
    comp = 1'b1;
    phi = 1'b1;
    repeat (2) @(negedge clk);
    rd_if.dout_ready = 1'b1;
    @(negedge clk);
    rd_if.dout_ready = 1'b0;
    n_vec++;
    if (rd_if.ovf !== 1'b0 || rd_if.dout !== 11'd1) begin
      n_err++;
      $display("FAIL pop_push_full: got ovf=%b d=%0d want ovf=0 d=1", rd_if.ovf, rd_if.dout);
    end
    @(negedge clk);
    phi = 1'b0;
    repeat (4) @(negedge clk);
    // overflow in the same cycle as ovf_clr keeps ovf set
    pulse(1'b0, 4);
    comp = 1'b0;
    phi = 1'b1;
    repeat (2) @(negedge clk);
    rd_if.ovf_clr = 1'b1;
    @(negedge clk);
    rd_if.ovf_clr = 1'b0;
    n_vec++;
    if (rd_if.ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_clr_collide: got %b want 1", rd_if.ovf);
    end
    @(negedge clk);
    phi = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rd_if.dout_valid !== 1'b1 || rd_if.dout !== exp[i]) begin
        n_err++;
        $display("FAIL drain%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, rd_if.dout_valid, rd_if.dout, exp[i]);
      end
      pop1();
    end
    n_vec++;
    if (rd_if.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: got %b want 0", rd_if.dout_valid);
    end
    rd_if.ovf_clr = 1'b1;
    @(negedge clk);
    rd_if.ovf_clr = 1'b0;
  endtask

`ifdef ACTRL_FB_OVERRIDE_EN
  task automatic test_override;
    en = 1'b0;
    dec_len = 10'd0;
    fb_ovr_en = 1'b1;
    fb_ovr_val = 1'b1;
    @(negedge clk);
    en = 1'b1;
    n_vec++;
    if (fb !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_latency: got %b want 1", fb);
    end
    pulse(1'b0, 4);
    n_vec++;
    if (fb !== 1'b1 || rd_if.dout_valid !== 1'b1 || rd_if.dout !== 11'd0) begin
      n_err++;
      $display("FAIL ovr_count: got fb=%b v=%b d=%0d want fb=1 v=1 d=0",
               fb, rd_if.dout_valid, rd_if.dout);
    end
    pop1();
    fb_ovr_en = 1'b0;
    fb_ovr_val = 1'b0;
  endtask
`endif

  task automatic test_reset_midrun;
    en = 1'b0;
    dec_len = 10'd0;
    @(negedge clk);
    en = 1'b1;
    pulse(1'b1, 4);
    pulse(1'b1, 4);
    for (int i = 0; i < 16; i++) begin
      if (cclk) break;
      @(negedge clk);
    end
    n_vec++;
    if (rd_if.dout_valid !== 1'b1 || fb !== 1'b1 || cclk !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_pre: got v=%b fb=%b cclk=%b want 1 1 1",
               rd_if.dout_valid, fb, cclk);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({cclk, lo, fb, div2, rd_if.dout_valid, rd_if.ovf} !== 6'b0 || rd_if.dout !== 11'd0) begin
      n_err++;
      $display("FAIL midrun_async: got bits=%b d=%0d want 000000 d=0",
               {cclk, lo, fb, div2, rd_if.dout_valid, rd_if.ovf}, rd_if.dout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rd_if.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_empty: got %b want 0", rd_if.dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_clkgen();
    test_decimate();
    test_max_window();
    test_fifo_ovf();
`ifdef ACTRL_FB_OVERRIDE_EN
    test_override();
`endif
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
